lfsr_stream_gen: RTL and testbench
==================================

LFSR_STREAM_GEN -- requirements
Module: lfsr_stream_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning LFSR state width (legal range 3..32).
REQ-002 SHALL have parameter TAPS, default 16'hB400, meaning the feedback mask: bit i set means state[i] enters the XOR.
REQ-003 SHALL have parameter SEED, default 1, meaning the nonzero state loaded at reset and used as the zero-seed substitute.
REQ-004 SHALL have parameter OUT_W, default 2, meaning output word width (1..WIDTH).
REQ-005 SHALL have parameter CNT_W, default 16, meaning burst length width.
REQ-006 SHALL have ports, in order:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- seed_load  in  1  load seed_in (IDLE only).
- seed_in  in  WIDTH  seed value.
- start  in  1  begin burst (IDLE only).
- len  in  CNT_W  burst word count, sampled with start.
- abort  in  1  terminate burst.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_W  equals state[WIDTH-1 -: OUT_W].
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- seed_err  out  1  one-cycle pulse when a zero seed is rejected.
- period_wrap  out  1  one-cycle pulse when the sequence returns to the active seed.

Function
REQ-007 Next state SHALL be {state[WIDTH-2:0], ^(state & TAPS)}, i.e. Fibonacci form shifting toward the MSB.
REQ-008 The LFSR SHALL advance only on handshake (out_valid && out_ready); it SHALL hold otherwise.
REQ-009 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-010 IDLE behaviour:
- out_valid=0, busy=0.
- start with len==0: go to DONE, no words emitted.
- start with len>0: latch len into the remaining-count register; go to RUN.
REQ-011 RUN behaviour:
- out_valid=1, busy=1.
- Each handshake decrements remaining.
- Handshake with remaining==1: go to DONE.
REQ-012 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-013 Abort in RUN SHALL go to IDLE next cycle with no done pulse; a handshake in that same cycle still advances the LFSR. Abort outside RUN SHALL be ignored.
REQ-014 Seed handling:
- start and seed_load outside IDLE SHALL be ignored.
- Simultaneous seed_load and start in IDLE: the seed loads first, and the burst's first word comes from the new seed.
REQ-015 seed_load with seed_in==0 SHALL load SEED instead and pulse seed_err the next cycle; the state SHALL never be all-zero.
REQ-016 The active seed register SHALL hold the last loaded seed (SEED after reset). period_wrap SHALL pulse in the cycle after a handshake whose next state equals the active seed.
REQ-017 out_data, out_valid and done SHALL be register- or state-derived, with no combinational path from out_ready.
REQ-018 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-019 Asserting rst_n low SHALL, asynchronously:
- set state=SEED and active seed=SEED;
- set FSM=IDLE and remaining=0;
- drive out_valid, busy, done, seed_err and period_wrap to 0;
- make out_data=SEED[WIDTH-1 -: OUT_W].
REQ-020 Reset mid-burst SHALL discard the burst with no done pulse; after release, operation SHALL resume from SEED.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and default tap masks for widths 3, 4, 8, 16 and 32 (e.g. TAPS_W3=3'b101).
REQ-022 The next-state function SHALL be a sub-module lfsr_core with parameters WIDTH and TAPS, input state, and output next_state. It SHALL be purely combinational; FSM, counter and seed logic SHALL stay in lfsr_stream_gen.

Verification
REQ-023 WIDTH=3, TAPS=3'b101, SEED=1, OUT_W=2; start, len=7, out_ready=1 -> out_data sequence 00,01,11,11,10,01,10; period_wrap pulses after the 7th handshake; done pulses one cycle later.
REQ-024 Same configuration; out_ready toggles 0/1 during a len=3 burst -> exactly 3 words (00,01,11), each held stable while stalled; done fires only after the 3rd handshake.
REQ-025 seed_load with seed_in=0 -> seed_err pulse; state=001. seed_load with seed_in=3'b110 -> first burst word=11; period_wrap fires when the state returns to 110.
REQ-026 len=0 start -> done pulses next cycle, out_valid never asserts, state unchanged.
REQ-027 len=5; abort after the 2nd handshake -> IDLE, no done, state=111. Then seed_load and start in the same cycle (seed_in=3'b100, len=1) -> single word 10.
REQ-028 rst_n low mid-burst (len=5, after 3 words) -> all outputs 0 immediately and out_data=00. After release, start len=1 -> word 00.

Source files
------------

// File: rtl/lfsr_stream_gen_pkg.sv
// Shared types and constants for the LFSR stream generator: FSM state encoding
// and default feedback masks for common widths.
package lfsr_stream_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Masks for the shift-toward-MSB Fibonacci form: bit i set taps state[i].
  localparam logic [2:0]  TAPS_W3  = 3'b101;
  localparam logic [3:0]  TAPS_W4  = 4'b1001;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'hA300_0000;

endpackage

// File: rtl/lfsr_stream_gen_core.sv
// Combinational next-state function of a Fibonacci LFSR that shifts toward the
// MSB and feeds the XOR of the tapped bits into bit 0.
module lfsr_core #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};

endmodule

// File: rtl/lfsr_stream_gen.sv
// Burst-oriented LFSR word source: emits len words over a valid/ready port,
// with seed loading, zero-seed rejection, abort and period-wrap detection.
module lfsr_stream_gen
  import lfsr_stream_gen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W16),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               OUT_W = 2,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic             period_wrap
);

  // Output port: a word transfers on a clock edge where out_valid && out_ready;
  // out_valid and out_data depend only on registers, never on out_ready.
  fsm_state_e       state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] active_seed_q, active_seed_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             seed_err_q, seed_err_d;
  logic             period_wrap_q, period_wrap_d;

  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_val;
  logic             handshake;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .state      (lfsr_q),
    .next_state (lfsr_next)
  );

  assign handshake = (state_q == RUN) && out_ready;
  assign seed_val  = (seed_in == '0) ? SEED : seed_in;

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    active_seed_d = active_seed_q;
    remaining_d   = remaining_q;
    seed_err_d    = 1'b0;
    period_wrap_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Seed is applied in the same edge as start, so the burst begins from it.
        if (seed_load) begin
          lfsr_d        = seed_val;
          active_seed_d = seed_val;
          seed_err_d    = (seed_in == '0);
        end
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            remaining_d = len;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (handshake) begin
          lfsr_d        = lfsr_next;
          remaining_d   = remaining_q - CNT_W'(1);
          period_wrap_d = (lfsr_next == active_seed_q);
        end
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (handshake && (remaining_q == CNT_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED;
      active_seed_q <= SEED;
      remaining_q   <= '0;
      seed_err_q    <= 1'b0;
      period_wrap_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      active_seed_q <= active_seed_d;
      remaining_q   <= remaining_d;
      seed_err_q    <= seed_err_d;
      period_wrap_q <= period_wrap_d;
    end
  end

  assign out_valid   = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign out_data    = lfsr_q[WIDTH-1 -: OUT_W];
  assign seed_err    = seed_err_q;
  assign period_wrap = period_wrap_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Self-checking bench for lfsr_stream_gen in a 3-bit configuration (taps 101,
// seed 001, 2-bit words); expected words come from hand-derived tables.
module tb_lfsr_stream_gen;
  import lfsr_stream_gen_pkg::*;

  localparam int W  = 3;
  localparam int OW = 2;
  localparam int CW = 16;

  typedef struct {
    int hs;
    int wrap_at;
    int wrap_cnt;
    int done_at;
    int done_cnt;
    int stall_bad;
    int stalls;
    int valid_cycles;
  } run_res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seed_load;
  logic [W-1:0]  seed_in;
  logic          start;
  logic [CW-1:0] len;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          seed_err;
  logic          period_wrap;

  int n_total = 0;
  int n_pass  = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] mon_exp;

  lfsr_stream_gen #(
    .WIDTH (W),
    .TAPS  (TAPS_W3),
    .SEED  (3'b001),
    .OUT_W (OW),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .start       (start),
    .len         (len),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .seed_err    (seed_err),
    .period_wrap (period_wrap)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every accepted word is popped and compared in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL word_unexpected: got %b, required no word", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp)
          $display("FAIL word: got %b, required %b", out_data, mon_exp);
        else
          n_pass++;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive_start(input logic [CW-1:0] n, input bit ld, input logic [W-1:0] sv);
    start     = 1'b1;
    len       = n;
    seed_load = ld;
    seed_in   = sv;
  endtask

  task automatic push_words(input logic [2*8-1:0] words, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(words[2*(7-i) +: 2]);
  endtask

  task automatic run_burst(input int max_cyc, input bit toggle, output run_res_t r);
    logic          held_valid;
    logic [OW-1:0] held;
    int            post;
    r = '{default: 0};
    r.wrap_at = -1;
    r.done_at = -1;
    held_valid = 1'b0;
    held = '0;
    post = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (period_wrap) begin
        r.wrap_cnt++;
        if (r.wrap_at < 0) r.wrap_at = r.hs;
      end
      if (done) begin
        r.done_cnt++;
        if (r.done_at < 0) r.done_at = r.hs;
      end
      if (held_valid && out_valid && (out_data !== held)) r.stall_bad++;
      held_valid = out_valid && !out_ready;
      held = out_data;
      if (held_valid) r.stalls++;
      if (out_valid) r.valid_cycles++;
      if (out_valid && out_ready) r.hs++;
      if (r.done_cnt > 0) post++;
      @(posedge clk);
      #1;
      start = 1'b0;
      seed_load = 1'b0;
      abort = 1'b0;
      if (toggle) out_ready = ~out_ready;
      if (post >= 2) break;
    end
  endtask

  // Tests
  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, busy, done, seed_err, period_wrap} !== 5'b0)
      $display("FAIL reset_flags: got %b, required 00000", {out_valid, busy, done, seed_err, period_wrap});
    else n_pass++;
    n_total++;
    if (out_data !== 2'b00) $display("FAIL reset_data: got %b, required 00", out_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++;
    if (dut.lfsr_q !== 3'b001) $display("FAIL reset_state: got %b, required 001", dut.lfsr_q);
    else n_pass++;
  endtask

  task automatic test_full_period();
    run_res_t r;
    out_ready = 1'b1;
    push_words(16'b00_01_11_11_10_01_10_00, 7);
    drive_start(7, 1'b0, '0);
    run_burst(40, 1'b0, r);
    n_total++;
    if (r.hs !== 7) $display("FAIL period_words: got %0d, required 7", r.hs); else n_pass++;
    n_total++;
    if (r.wrap_at !== 7 || r.wrap_cnt !== 1)
      $display("FAIL period_wrap: got at=%0d cnt=%0d, required at=7 cnt=1", r.wrap_at, r.wrap_cnt);
    else n_pass++;
    n_total++;
    if (r.done_at !== 7 || r.done_cnt !== 1)
      $display("FAIL period_done: got at=%0d cnt=%0d, required at=7 cnt=1", r.done_at, r.done_cnt);
    else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL period_drain: got %0d left, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_res_t r;
    out_ready = 1'b0;
    push_words(16'b00_01_11_00_00_00_00_00, 3);
    drive_start(3, 1'b0, '0);
    run_burst(40, 1'b1, r);
    n_total++;
    if (r.hs !== 3) $display("FAIL bp_words: got %0d, required 3", r.hs); else n_pass++;
    n_total++;
    if (r.stall_bad !== 0 || r.stalls < 2)
      $display("FAIL bp_stable: got bad=%0d stalls=%0d, required bad=0 stalls>=2", r.stall_bad, r.stalls);
    else n_pass++;
    n_total++;
    if (r.done_at !== 3 || r.done_cnt !== 1 || r.wrap_cnt !== 0)
      $display("FAIL bp_done: got at=%0d cnt=%0d wrap=%0d, required 3/1/0", r.done_at, r.done_cnt, r.wrap_cnt);
    else n_pass++;
  endtask

  task automatic test_seed();
    run_res_t r;
    seed_load = 1'b1;
    seed_in = 3'b000;
    tick();
    seed_load = 1'b0;
    n_total++;
    if (seed_err !== 1'b1 || dut.lfsr_q !== 3'b001)
      $display("FAIL seed_zero: got err=%b state=%b, required err=1 state=001", seed_err, dut.lfsr_q);
    else n_pass++;
    tick();
    n_total++;
    if (seed_err !== 1'b0) $display("FAIL seed_err_pulse: got %b, required 0", seed_err); else n_pass++;
    seed_load = 1'b1;
    seed_in = 3'b110;
    tick();
    seed_load = 1'b0;
    n_total++;
    if (seed_err !== 1'b0 || dut.lfsr_q !== 3'b110)
      $display("FAIL seed_load: got err=%b state=%b, required err=0 state=110", seed_err, dut.lfsr_q);
    else n_pass++;
    out_ready = 1'b1;
    push_words(16'b11_10_01_10_00_01_11_00, 7);
    drive_start(7, 1'b0, '0);
    run_burst(40, 1'b0, r);
    n_total++;
    if (r.hs !== 7 || r.wrap_at !== 7 || r.wrap_cnt !== 1 || r.done_cnt !== 1)
      $display("FAIL seed_wrap: got hs=%0d at=%0d cnt=%0d done=%0d, required 7/7/1/1",
               r.hs, r.wrap_at, r.wrap_cnt, r.done_cnt);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    out_ready = 1'b1;
    drive_start(0, 1'b0, '0);
    tick();
    start = 1'b0;
    n_total++;
    if ({done, busy, out_valid} !== 3'b110)
      $display("FAIL len0_done: got done/busy/valid=%b, required 110", {done, busy, out_valid});
    else n_pass++;
    tick();
    n_total++;
    if ({done, busy, out_valid} !== 3'b000 || dut.lfsr_q !== 3'b110)
      $display("FAIL len0_idle: got flags=%b state=%b, required 000 state=110",
               {done, busy, out_valid}, dut.lfsr_q);
    else n_pass++;
  endtask

  task automatic test_abort();
    run_res_t r;
    apply_reset();
    out_ready = 1'b1;
    push_words(16'b00_01_00_00_00_00_00_00, 2);
    drive_start(5, 1'b0, '0);
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++;
    if ({done, busy, out_valid} !== 3'b000 || dut.lfsr_q !== 3'b111)
      $display("FAIL abort_idle: got flags=%b state=%b, required 000 state=111",
               {done, busy, out_valid}, dut.lfsr_q);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || exp_q.size() !== 0)
      $display("FAIL abort_nodone: got done=%b left=%0d, required 0/0", done, exp_q.size());
    else n_pass++;
    // abort raised in IDLE alongside start must not cancel the burst
    out_ready = 1'b1;
    push_words(16'b10_00_00_00_00_00_00_00, 1);
    drive_start(1, 1'b1, 3'b100);
    abort = 1'b1;
    run_burst(20, 1'b0, r);
    n_total++;
    if (r.hs !== 1 || r.done_cnt !== 1 || exp_q.size() !== 0)
      $display("FAIL abort_seed_start: got hs=%0d done=%0d left=%0d, required 1/1/0",
               r.hs, r.done_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    run_res_t r;
    out_ready = 1'b1;
    push_words(16'b00_01_11_00_00_00_00_00, 3);
    drive_start(5, 1'b0, '0);
    tick();
    start = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, busy, done, seed_err, period_wrap} !== 5'b0 || out_data !== 2'b00)
      $display("FAIL midrst_outputs: got flags=%b data=%b, required 00000 data=00",
               {out_valid, busy, done, seed_err, period_wrap}, out_data);
    else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL midrst_words: got %0d left, required 0", exp_q.size());
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    push_words(16'b00_00_00_00_00_00_00_00, 1);
    drive_start(1, 1'b0, '0);
    run_burst(20, 1'b0, r);
    n_total++;
    if (r.hs !== 1 || r.done_cnt !== 1 || exp_q.size() !== 0)
      $display("FAIL midrst_resume: got hs=%0d done=%0d left=%0d, required 1/1/0",
               r.hs, r.done_cnt, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b1;
    seed_load = 1'b0;
    seed_in = '0;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_period();
    test_backpressure();
    test_seed();
    test_len_zero();
    test_abort();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
